irq_collector: RTL and testbench
================================

IRQ_COLLECTOR -- requirements
Module: irq_collector

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 15: number of interrupt input lines.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: event counter width.
REQ-003 SHALL have port clk_100, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_100, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port irq_in, input, NUM_IRQ: interrupt pulses synchronous to clk_100, one per line, from timer_inetrrupt and peers.
REQ-006 SHALL have port reg_wr, input, 1: register write strobe, one cycle.
REQ-007 SHALL have port reg_rd, input, 1: register read strobe, one cycle.
REQ-008 SHALL have port reg_addr, input, 3: register word index.
REQ-009 SHALL have port reg_wdata, input, 32: write data.
REQ-010 SHALL have port reg_rdata, output, 32: read data.
REQ-011 SHALL have port reg_rvalid, output, 1: read data valid.
REQ-012 SHALL have port irq_out, output, 1: level interrupt to MicroBlaze.

Function
REQ-013 SHALL register irq_in each cycle into irq_d and define rise = irq_in AND NOT irq_d.
REQ-014 SHALL set pending[i] in the cycle after rise[i], regardless of enable[i].
REQ-015 SHALL set overrun[i] when rise[i] occurs while pending[i] is already 1.
REQ-016 SHALL use this register map (index: register): 0 PENDING (RO); 1 ENABLE (RW); 2 CLEAR (WO, write-1-to-clear pending and overrun, reads 0); 3 OVERRUN (RO); 4 EVENT_CNT (RO, any write clears it); 5 STATUS (bit0 = irq_out, other bits 0); 6-7 reserved (reads 0, writes ignored).
REQ-017 SHALL give set priority when rise[i] and a CLEAR bit i occur in the same cycle: pending[i] stays 1 and overrun[i] is cleared.
REQ-018 SHALL register irq_out = OR(pending AND enable), giving 2-cycle latency from rise to irq_out.
REQ-019 SHALL deassert irq_out the cycle after pending AND enable becomes zero.
REQ-020 SHALL increment EVENT_CNT by exactly 1 in each cycle with at least one rise on an enabled line, however many lines rise.
REQ-021 SHALL saturate EVENT_CNT at all-ones.
REQ-022 SHALL apply the clear when a write to index 4 coincides with an increment.
REQ-023 SHALL, for reg_rd in cycle N, drive reg_rdata with the register value sampled in cycle N and assert reg_rvalid for exactly cycle N+1.
REQ-024 SHALL drive reg_rdata to 0 in all cycles without reg_rvalid.
REQ-025 SHALL execute both a read and a write in the same cycle; the read returns the pre-write value.
REQ-026 SHALL zero-extend fields narrower than 32 bits on read and ignore upper write bits.
REQ-027 SHALL take effect on a write to ENABLE in the next cycle.

Reset
REQ-028 SHALL on rst_100 assertion immediately clear pending, overrun, enable, EVENT_CNT, irq_out, reg_rvalid and reg_rdata to 0.
REQ-029 SHALL reset irq_d to all-ones, so that lines already high at reset release register no edge.
REQ-030 SHALL abort a read in flight when reset asserts mid-operation; reg_rvalid stays 0.

Structure
REQ-031 SHALL place register index constants, NUM_IRQ default and CNT_WIDTH default in shared package irq_collector_pkg.
REQ-032 SHALL implement edge detection (irq_d, rise) in sub-module irq_edge_detect, parameterized by NUM_IRQ.

Verification
REQ-033 SHALL cover: 1-cycle pulse on irq_in[0] with ENABLE=0x1 -> PENDING=0x0001, irq_out high 2 cycles after rise, EVENT_CNT=1.
REQ-034 SHALL cover: pulse on irq_in[3] with ENABLE=0 -> PENDING=0x0008, irq_out stays 0, EVENT_CNT unchanged.
REQ-035 SHALL cover: second pulse on line 0 before clear -> OVERRUN=0x0001; write CLEAR=0x1 -> PENDING=0, OVERRUN=0, irq_out low one cycle later.
REQ-036 SHALL cover: rise on line 5 in the same cycle as CLEAR=0x20 -> PENDING bit 5 remains 1, irq_out remains asserted if enabled.
REQ-037 SHALL cover: lines 0-14 rise together with ENABLE=0x7FFF -> EVENT_CNT increments by 1; 70000 enabled events -> EVENT_CNT=0xFFFF.
REQ-038 SHALL cover: irq_in=0x7FFF held across reset release -> PENDING=0; rst_100 asserted during a read -> reg_rvalid 0 and all registers 0.

Source files
------------

// File: rtl/irq_collector_pkg.sv
// Shared constants for the interrupt collector: register word indices and
// default sizing.
package irq_collector_pkg;

    localparam int NUM_IRQ_DEF   = 15;
    localparam int CNT_WIDTH_DEF = 16;

    localparam logic [2:0] REG_PENDING   = 3'd0;
    localparam logic [2:0] REG_ENABLE    = 3'd1;
    localparam logic [2:0] REG_CLEAR     = 3'd2;
    localparam logic [2:0] REG_OVERRUN   = 3'd3;
    localparam logic [2:0] REG_EVENT_CNT = 3'd4;
    localparam logic [2:0] REG_STATUS    = 3'd5;

endpackage

// File: rtl/irq_collector_if.sv
// Register bus between the processor-side master and the interrupt collector.
interface irq_collector_if;

    logic        reg_wr;
    logic        reg_rd;
    logic [2:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;

    modport master (
        output reg_wr, reg_rd, reg_addr, reg_wdata,
        input  reg_rdata, reg_rvalid
    );

    modport slave (
        input  reg_wr, reg_rd, reg_addr, reg_wdata,
        output reg_rdata, reg_rvalid
    );

endinterface

// File: rtl/irq_collector_edge_detect.sv
// Rising-edge detector for the interrupt lines; the delayed copy resets high so
// lines already asserted when reset releases produce no edge.
module irq_edge_detect #(
    parameter int NUM_IRQ = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] i_irq,
    output logic [NUM_IRQ-1:0] o_rise
);

    logic [NUM_IRQ-1:0] r_irq_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_d <= '1;
        end else begin
            r_irq_d <= i_irq;
        end
    end

    assign o_rise = i_irq & ~r_irq_d;

endmodule

// File: rtl/irq_collector.sv
// Interrupt collector: latches rising edges into pending/overrun, masks with
// enable into a registered level interrupt, and counts enabled edge cycles.
module irq_collector
    import irq_collector_pkg::*;
#(
    parameter int NUM_IRQ   = NUM_IRQ_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic               clk_100,
    input  logic               rst_100,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out,
    irq_collector_if.slave     bus
);

    logic [NUM_IRQ-1:0]   w_rise;
    logic [NUM_IRQ-1:0]   w_wr_mask;
    logic [NUM_IRQ-1:0]   w_clr;
    logic                 w_wr_enable;
    logic                 w_wr_cnt;
    logic                 w_inc;
    logic [31:0]          w_rd_mux;
    logic                 w_unused;

    logic [NUM_IRQ-1:0]   r_pending;
    logic [NUM_IRQ-1:0]   r_overrun;
    logic [NUM_IRQ-1:0]   r_enable;
    logic [CNT_WIDTH-1:0] r_event_cnt;
    logic                 r_irq_out;
    logic                 r_rvalid;
    logic [31:0]          r_rdata;

    irq_edge_detect #(
        .NUM_IRQ (NUM_IRQ)
    ) u_edge (
        .clk    (clk_100),
        .rst    (rst_100),
        .i_irq  (irq_in),
        .o_rise (w_rise)
    );

    assign w_wr_mask   = bus.reg_wdata[NUM_IRQ-1:0];
    assign w_wr_enable = bus.reg_wr && (bus.reg_addr == REG_ENABLE);
    assign w_wr_cnt    = bus.reg_wr && (bus.reg_addr == REG_EVENT_CNT);
    assign w_clr       = (bus.reg_wr && (bus.reg_addr == REG_CLEAR)) ? w_wr_mask : '0;
    assign w_inc       = |(w_rise & r_enable);
    assign w_unused    = &{1'b0, bus.reg_wdata};

    always_comb begin
        w_rd_mux = '0;
        case (bus.reg_addr)
            REG_PENDING:   w_rd_mux = 32'(r_pending);
            REG_ENABLE:    w_rd_mux = 32'(r_enable);
            REG_OVERRUN:   w_rd_mux = 32'(r_overrun);
            REG_EVENT_CNT: w_rd_mux = 32'(r_event_cnt);
            REG_STATUS:    w_rd_mux = {31'b0, r_irq_out};
            default:       w_rd_mux = '0;
        endcase
    end

    // A new edge beats a clear on pending, but the clear still wins on overrun.
    always_ff @(posedge clk_100 or posedge rst_100) begin
        if (rst_100) begin
            r_pending   <= '0;
            r_overrun   <= '0;
            r_enable    <= '0;
            r_event_cnt <= '0;
            r_irq_out   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_overrun <= (r_overrun | (w_rise & r_pending)) & ~w_clr;
            if (w_wr_enable) begin
                r_enable <= w_wr_mask;
            end
            r_irq_out <= |(r_pending & r_enable);
            if (w_wr_cnt) begin
                r_event_cnt <= '0;
            end else if (w_inc && (r_event_cnt != '1)) begin
                r_event_cnt <= r_event_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            r_rvalid <= bus.reg_rd;
            r_rdata  <= bus.reg_rd ? w_rd_mux : '0;
        end
    end

    assign irq_out        = r_irq_out;
    assign bus.reg_rvalid = r_rvalid;
    assign bus.reg_rdata  = r_rdata;

endmodule

// File: tb/tb_irq_collector.sv
// Directed bench for irq_collector: reads push expected data into a queue and
// a monitor pops and compares whenever reg_rvalid is seen.
module tb_irq_collector;
    import irq_collector_pkg::*;

    typedef struct {
        logic [31:0] data;
        string       name;
    } exp_t;

    logic        clk_100 = 1'b0;
    logic        rst_100 = 1'b1;
    logic [14:0] irq_in  = '0;
    logic        irq_out;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    irq_collector_if bus ();

    irq_collector dut (
        .clk_100 (clk_100),
        .rst_100 (rst_100),
        .irq_in  (irq_in),
        .irq_out (irq_out),
        .bus     (bus)
    );

    always #5 clk_100 = ~clk_100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_100);
            #1;
            if (bus.reg_rvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got rvalid=1 with rdata 0x%08h required rvalid=0", bus.reg_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check(e.name, bus.reg_rdata, e.data);
                end
            end else begin
                check("rdata_idle_zero", bus.reg_rdata, 32'h0);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk_100);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        bus.reg_wr    = 1'b1;
        bus.reg_addr  = addr;
        bus.reg_wdata = data;
        step();
        bus.reg_wr    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] addr, input logic [31:0] data, input string name);
        exp_q.push_back('{data, name});
        bus.reg_rd   = 1'b1;
        bus.reg_addr = addr;
        step();
        bus.reg_rd   = 1'b0;
    endtask

    task automatic chk_irq(input string name, input logic req);
        check(name, {31'b0, irq_out}, {31'b0, req});
    endtask

    initial begin
        bus.reg_wr    = 1'b0;
        bus.reg_rd    = 1'b0;
        bus.reg_addr  = '0;
        bus.reg_wdata = '0;
        step(3);
        chk_irq("reset_irq_out", 1'b0);
        rst_100 = 1'b0;
        step();
        for (int i = 0; i < 8; i++) rd(3'(i), 32'h0, $sformatf("reset_reg%0d", i));

        // single pulse on line 0, enabled
        wr(REG_ENABLE, 32'h1);
        irq_in = 15'h1;
        step();
        chk_irq("t1_irq_lat1", 1'b0);
        irq_in = '0;
        step();
        chk_irq("t1_irq_lat2", 1'b1);
        rd(REG_PENDING, 32'h1, "t1_pending");
        rd(REG_EVENT_CNT, 32'h1, "t1_cnt");
        rd(REG_STATUS, 32'h1, "t1_status");

        // second pulse before clear -> overrun, then clear
        irq_in = 15'h1;
        step();
        irq_in = '0;
        step();
        rd(REG_OVERRUN, 32'h1, "t3_overrun");
        rd(REG_PENDING, 32'h1, "t3_pending");
        wr(REG_CLEAR, 32'h1);
        chk_irq("t3_irq_hold", 1'b1);
        step();
        chk_irq("t3_irq_low", 1'b0);
        rd(REG_PENDING, 32'h0, "t3_pending_clr");
        rd(REG_OVERRUN, 32'h0, "t3_overrun_clr");
        rd(REG_CLEAR, 32'h0, "clear_reads_zero");

        // masked line 3
        wr(REG_ENABLE, 32'h0);
        irq_in = 15'h8;
        step();
        irq_in = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_irq("t2_irq_masked", 1'b0);
        end
        rd(REG_PENDING, 32'h8, "t2_pending");
        rd(REG_EVENT_CNT, 32'h2, "t2_cnt");
        wr(REG_CLEAR, 32'h8);
        rd(REG_PENDING, 32'h0, "t2_pending_clr");

        // rise on line 5 coinciding with its clear
        wr(REG_ENABLE, 32'h20);
        irq_in = 15'h20;
        step();
        irq_in = '0;
        step();
        chk_irq("t4_irq_set", 1'b1);
        irq_in        = 15'h20;
        bus.reg_wr    = 1'b1;
        bus.reg_addr  = REG_CLEAR;
        bus.reg_wdata = 32'h20;
        step();
        irq_in     = '0;
        bus.reg_wr = 1'b0;
        chk_irq("t4_irq_hold1", 1'b1);
        step();
        chk_irq("t4_irq_hold2", 1'b1);
        rd(REG_PENDING, 32'h20, "t4_pending_kept");
        rd(REG_OVERRUN, 32'h0, "t4_overrun_cleared");
        rd(REG_EVENT_CNT, 32'h4, "t4_cnt");

        // simultaneous read and write returns the old value; upper bits ignored
        exp_q.push_back('{32'h20, "rw_same_cycle_old"});
        bus.reg_rd    = 1'b1;
        bus.reg_wr    = 1'b1;
        bus.reg_addr  = REG_ENABLE;
        bus.reg_wdata = 32'hFFFF_FFFF;
        step();
        bus.reg_rd = 1'b0;
        bus.reg_wr = 1'b0;
        rd(REG_ENABLE, 32'h7FFF, "enable_upper_ignored");
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd6, 32'h0, "reserved6");
        rd(3'd7, 32'h0, "reserved7");
        wr(REG_CLEAR, 32'h7FFF);
        rd(REG_PENDING, 32'h0, "clear_all");
        rd(REG_STATUS, 32'h0, "status_low");

        // all lines together count once; then saturate
        wr(REG_EVENT_CNT, 32'h0);
        rd(REG_EVENT_CNT, 32'h0, "cnt_write_clears");
        irq_in = 15'h7FFF;
        step();
        irq_in = '0;
        step();
        rd(REG_EVENT_CNT, 32'h1, "all_lines_one_inc");
        rd(REG_PENDING, 32'h7FFF, "all_lines_pending");
        for (int i = 0; i < 70000; i++) begin
            irq_in = (i % 2 == 1) ? 15'h2 : 15'h1;
            step();
        end
        irq_in = '0;
        step();
        rd(REG_EVENT_CNT, 32'hFFFF, "cnt_saturated");
        rd(REG_OVERRUN, 32'h3, "burst_overrun");
        irq_in        = 15'h1;
        bus.reg_wr    = 1'b1;
        bus.reg_addr  = REG_EVENT_CNT;
        bus.reg_wdata = 32'h0;
        step();
        irq_in     = '0;
        bus.reg_wr = 1'b0;
        rd(REG_EVENT_CNT, 32'h0, "cnt_clear_beats_inc");

        // reset during a read, lines held high across release
        irq_in       = 15'h7FFF;
        bus.reg_rd   = 1'b1;
        bus.reg_addr = REG_PENDING;
        #2;
        rst_100 = 1'b1;
        @(posedge clk_100);
        #1;
        check("rst_rvalid", {31'b0, bus.reg_rvalid}, 32'h0);
        check("rst_rdata", bus.reg_rdata, 32'h0);
        chk_irq("rst_irq_out_mid", 1'b0);
        @(negedge clk_100);
        bus.reg_rd = 1'b0;
        step(2);
        rst_100 = 1'b0;
        step(2);
        for (int i = 0; i < 8; i++) rd(3'(i), 32'h0, $sformatf("post_reset_reg%0d", i));
        chk_irq("post_reset_irq_out", 1'b0);
        irq_in = '0;
        step(3);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
